// File: rtl/otter_ecc_scrubber_if.sv
// OTTER ECC scrubber data-port bundle.
// The scrubber is master; memory and CPU arbitration are the slave side.
interface otter_ecc_scrubber_if;
  logic        SCRUB_REQ;
  logic        SCRUB_WE;
  logic [31:0] SCRUB_ADDR;
  logic [31:0] SCRUB_DOUT;
  logic        CPU_BUSY;
  logic        CPU_WE;
  logic [31:0] CPU_ADDR;
  logic [31:0] MEM_DIN;
  logic [5:0]  PAR_DIN;

  modport master (
    output SCRUB_REQ, SCRUB_WE, SCRUB_ADDR, SCRUB_DOUT,
    input  CPU_BUSY, CPU_WE, CPU_ADDR, MEM_DIN, PAR_DIN
  );

  modport slave (
    input  SCRUB_REQ, SCRUB_WE, SCRUB_ADDR, SCRUB_DOUT,
    output CPU_BUSY, CPU_WE, CPU_ADDR, MEM_DIN, PAR_DIN
  );
endinterface

// File: rtl/otter_ecc_scrubber.sv
// OTTER background memory scrubber with Hamming(38,32) single-error
// correction, idle-cycle stealing and error statistics.
module otter_ecc_scrubber #(
  parameter int ADDR_WIDTH     = 14,
  parameter int SCRUB_INTERVAL = 256,
  parameter int READ_LAT       = 1
) (
  input  logic                 MEM_CLK,
  input  logic                 MEM_RST_N,
  input  logic                 SCRUB_EN,
  input  logic                 ERR_CLR,
  otter_ecc_scrubber_if.master bus,
  output logic [15:0]          ERR_CORR_CNT,
  output logic                 ERR_UNCORR,
  output logic [31:0]          ERR_ADDR,
  output logic                 ERR_IRQ,
  output logic                 PASS_DONE
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_READ, S_LAT,
    S_CHECK, S_WRITE, S_NEXT
  } state_t;

  localparam int IW = (SCRUB_INTERVAL > 1) ?
                      $clog2(SCRUB_INTERVAL) : 1;
  localparam int LW = (READ_LAT > 1) ?
                      $clog2(READ_LAT) : 1;
  localparam logic [IW-1:0] I_LAST =
    IW'((SCRUB_INTERVAL > 0) ? SCRUB_INTERVAL - 1 : 0);
  localparam logic [LW-1:0] L_LAST =
    LW'((READ_LAT > 0) ? READ_LAT - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] IDX_LAST = '1;
  localparam state_t S_FIRST =
    (SCRUB_INTERVAL == 0) ? S_READ : S_WAIT;

  function automatic logic [5:0] hamming_chk(
    input logic [31:0] d
  );
    logic [5:0] c;
    logic [4:0] j;
    c = '0;
    j = '0;
    for (int pos = 3; pos < 39; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c = c ^ ({6{d[j]}} & 6'(pos));
        j = j + 5'd1;
      end
    end
    return c;
  endfunction

  // Check-bit syndromes map to no data bit, giving an all-zero mask.
  function automatic logic [31:0] flip_mask(
    input logic [5:0] s
  );
    logic [31:0] m;
    logic [4:0]  j;
    m = '0;
    j = '0;
    for (int pos = 3; pos < 39; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (s == 6'(pos)) m[j] = 1'b1;
        j = j + 5'd1;
      end
    end
    return m;
  endfunction

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [IW-1:0]           wcnt;
  logic [LW-1:0]           lcnt;
  logic [31:0]             data_q;
  logic [5:0]              par_q;
  logic [31:0]             dout_q;
  logic [15:0]             corr_cnt;
  logic                    uncorr_q;
  logic [31:0]             err_addr_q;
  logic                    irq_q;
  logic                    pass_q;

  logic [31:0] word_addr;
  logic        snoop;
  logic [5:0]  syn;
  logic        s_clean;
  logic        s_uncorr;
  logic        s_fix;
  logic        unused_addr;

  assign word_addr = {{(30-ADDR_WIDTH){1'b0}}, idx, 2'b00};
  assign snoop     = bus.CPU_WE &&
                     (bus.CPU_ADDR[ADDR_WIDTH+1:2] == idx);
  assign syn       = par_q ^ hamming_chk(data_q);
  assign s_clean   = (syn == 6'd0);
  assign s_uncorr  = (syn > 6'd38);
  assign s_fix     = !s_clean && !s_uncorr;

  assign unused_addr = ^{bus.CPU_ADDR[31:ADDR_WIDTH+2],
                         bus.CPU_ADDR[1:0]};

  // Requests are gated by CPU_BUSY in the same cycle: never speculative.
  assign bus.SCRUB_REQ  = !bus.CPU_BUSY &&
                          ((state == S_READ) ||
                           (state == S_WRITE && !snoop));
  assign bus.SCRUB_WE   = !bus.CPU_BUSY &&
                          (state == S_WRITE) && !snoop;
  assign bus.SCRUB_ADDR = word_addr;
  assign bus.SCRUB_DOUT = dout_q;

  assign ERR_CORR_CNT = corr_cnt;
  assign ERR_UNCORR   = uncorr_q;
  assign ERR_ADDR     = err_addr_q;
  assign ERR_IRQ      = irq_q;
  assign PASS_DONE    = pass_q;

  always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
    if (!MEM_RST_N) begin
      state      <= S_IDLE;
      idx        <= '0;
      wcnt       <= '0;
      lcnt       <= '0;
      data_q     <= '0;
      par_q      <= '0;
      dout_q     <= '0;
      corr_cnt   <= '0;
      uncorr_q   <= 1'b0;
      err_addr_q <= '0;
      irq_q      <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      irq_q  <= 1'b0;
      pass_q <= 1'b0;
      if (ERR_CLR) begin
        corr_cnt   <= '0;
        uncorr_q   <= 1'b0;
        err_addr_q <= '0;
      end
      unique case (state)
        S_IDLE: begin
          if (SCRUB_EN) begin
            wcnt  <= '0;
            state <= S_FIRST;
          end
        end
        S_WAIT: begin
          if (wcnt == I_LAST) begin
            wcnt  <= '0;
            state <= S_READ;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_READ: begin
          if (!bus.CPU_BUSY) begin
            lcnt <= '0;
            if (READ_LAT == 0) begin
              data_q <= bus.MEM_DIN;
              par_q  <= bus.PAR_DIN;
              state  <= S_CHECK;
            end else begin
              state <= S_LAT;
            end
          end
        end
        S_LAT: begin
          if (snoop) begin
            state <= S_NEXT;
          end else if (lcnt == L_LAST) begin
            data_q <= bus.MEM_DIN;
            par_q  <= bus.PAR_DIN;
            state  <= S_CHECK;
          end else begin
            lcnt <= lcnt + 1'b1;
          end
        end
        S_CHECK: begin
          state <= S_NEXT;
          if (!snoop) begin
            unique case (1'b1)
              s_clean: begin
              end
              s_fix: begin
                dout_q     <= data_q ^ flip_mask(syn);
                corr_cnt   <= ERR_CLR ? 16'd1 :
                              (corr_cnt == 16'hFFFF) ? corr_cnt :
                              corr_cnt + 16'd1;
                err_addr_q <= word_addr;
                irq_q      <= 1'b1;
                state      <= S_WRITE;
              end
              s_uncorr: begin
                uncorr_q   <= 1'b1;
                err_addr_q <= word_addr;
                irq_q      <= 1'b1;
              end
            endcase
          end
        end
        S_WRITE: begin
          if (snoop || !bus.CPU_BUSY) state <= S_NEXT;
        end
        S_NEXT: begin
          idx    <= idx + 1'b1;
          pass_q <= (idx == IDX_LAST);
          wcnt   <= '0;
          state  <= SCRUB_EN ? S_FIRST : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_ecc_scrubber.sv
// Directed bench for otter_ecc_scrubber: small 16-word memory,
// back-to-back scrubbing, hand-computed Hamming vectors.
module tb_otter_ecc_scrubber;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic [15:0] cnt;
  logic unc;
  logic [31:0] eaddr;
  logic irq;
  logic pass;

  otter_ecc_scrubber_if bus();

  otter_ecc_scrubber #(
    .ADDR_WIDTH(4),
    .SCRUB_INTERVAL(0),
    .READ_LAT(1)
  ) dut (
    .MEM_CLK(clk),
    .MEM_RST_N(rst_n),
    .SCRUB_EN(en),
    .ERR_CLR(clr),
    .bus(bus),
    .ERR_CORR_CNT(cnt),
    .ERR_UNCORR(unc),
    .ERR_ADDR(eaddr),
    .ERR_IRQ(irq),
    .PASS_DONE(pass)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Parity by walking data bits and skipping power-of-two positions.
  function automatic logic [5:0] tb_enc(input logic [31:0] d);
    logic [5:0] c;
    int p;
    c = '0;
    p = 2;
    for (int i = 0; i < 32; i++) begin
      p++;
      if ((p & (p - 1)) == 0) p++;
      if (d[i[4:0]]) c = c ^ 6'(p);
    end
    return c;
  endfunction

  logic [31:0] mem_m [16];
  logic [5:0]  par_m [16];
  logic [31:0] rd_d = '0;
  logic [5:0]  rd_p = '0;
  logic        pk_en = 1'b0;
  logic [3:0]  pk_a = '0;
  logic [31:0] pk_d = '0;
  logic [5:0]  pk_p = '0;
  logic [31:0] cpu_wdata = '0;

  int cyc = 0;
  int wr_cnt = 0;
  int irq_cnt = 0;
  int pass_cnt = 0;
  int pass_last = 0;
  int pass_prev = 0;
  int busy_viol = 0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  assign bus.MEM_DIN = rd_d;
  assign bus.PAR_DIN = rd_p;

  always @(posedge clk) begin
    cyc++;
    if (pk_en) begin
      mem_m[pk_a] <= pk_d;
      par_m[pk_a] <= pk_p;
    end
    if (bus.SCRUB_REQ && bus.CPU_BUSY) busy_viol++;
    if (bus.SCRUB_REQ && bus.SCRUB_WE) begin
      wr_cnt++;
      wr_addr = bus.SCRUB_ADDR;
      wr_data = bus.SCRUB_DOUT;
      mem_m[bus.SCRUB_ADDR[5:2]] <= bus.SCRUB_DOUT;
      par_m[bus.SCRUB_ADDR[5:2]] <= tb_enc(bus.SCRUB_DOUT);
    end else if (bus.SCRUB_REQ) begin
      rd_d <= mem_m[bus.SCRUB_ADDR[5:2]];
      rd_p <= par_m[bus.SCRUB_ADDR[5:2]];
    end
    if (bus.CPU_WE) begin
      mem_m[bus.CPU_ADDR[5:2]] <= cpu_wdata;
      par_m[bus.CPU_ADDR[5:2]] <= tb_enc(cpu_wdata);
    end
    if (irq) irq_cnt++;
    if (pass) begin
      pass_cnt++;
      pass_prev = pass_last;
      pass_last = cyc;
    end
  end

  task automatic poke(input int a, input logic [31:0] d,
                      input logic [5:0] p);
    pk_en = 1'b1;
    pk_a = 4'(a);
    pk_d = d;
    pk_p = p;
    @(negedge clk);
    pk_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    clr = 1'b0;
    bus.CPU_BUSY = 1'b0;
    bus.CPU_WE = 1'b0;
    bus.CPU_ADDR = '0;
    @(negedge clk);
    for (int a = 0; a < 16; a++) poke(a, 32'h0, 6'h0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_pass(input string tag);
    int p0;
    int n;
    p0 = pass_cnt;
    n = 0;
    while (pass_cnt == p0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(pass_cnt - p0), 32'd1);
  endtask

  task automatic wait_rd(input string tag, input logic [31:0] a);
    int n;
    n = 0;
    while (!(bus.SCRUB_REQ && !bus.SCRUB_WE &&
             bus.SCRUB_ADDR == a) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 300), 32'd1);
  endtask

  int w0, i0, v0;

  initial begin
    bus.CPU_BUSY = 1'b0;
    bus.CPU_WE = 1'b0;
    bus.CPU_ADDR = '0;

    do_reset();
    chk("rst_flags", {27'd0, bus.SCRUB_REQ, bus.SCRUB_WE,
                      unc, irq, pass}, 32'd0);
    chk("rst_addr", bus.SCRUB_ADDR, 32'h0);
    chk("rst_dout", bus.SCRUB_DOUT, 32'h0);
    chk("rst_cnt", {16'd0, cnt}, 32'h0);
    chk("rst_eaddr", eaddr, 32'h0);

    // clean memory: two passes, 4 cycles per word
    w0 = wr_cnt;
    i0 = irq_cnt;
    en = 1'b1;
    wait_pass("clean_pass1");
    wait_pass("clean_pass2");
    en = 1'b0;
    chk("clean_period", 32'(pass_last - pass_prev), 32'd64);
    chk("clean_wr", 32'(wr_cnt - w0), 32'd0);
    chk("clean_irq", 32'(irq_cnt - i0), 32'd0);
    chk("clean_cnt", {16'd0, cnt}, 32'h0);

    // single data-bit error at idx 5, S=3
    do_reset();
    poke(5, 32'h1, 6'h00);
    w0 = wr_cnt;
    i0 = irq_cnt;
    en = 1'b1;
    wait_pass("d_pass");
    en = 1'b0;
    chk("d_wr_n", 32'(wr_cnt - w0), 32'd1);
    chk("d_wr_addr", wr_addr, 32'h14);
    chk("d_wr_data", wr_data, 32'h0);
    chk("d_cnt", {16'd0, cnt}, 32'd1);
    chk("d_eaddr", eaddr, 32'h14);
    chk("d_irq", 32'(irq_cnt - i0), 32'd1);
    chk("d_unc", {31'd0, unc}, 32'd0);

    // S=4 check bit, S=5 on nonzero data, S=38 top bit, S=39
    do_reset();
    poke(2, 32'h0, 6'b000100);
    poke(9, 32'h3, 6'b000011);
    poke(12, 32'h0, 6'b100110);
    poke(14, 32'h0, 6'b100111);
    w0 = wr_cnt;
    i0 = irq_cnt;
    en = 1'b1;
    wait_pass("m_pass1");
    chk("m_wr_n", 32'(wr_cnt - w0), 32'd3);
    chk("m_par2", {26'd0, par_m[2]}, 32'h0);
    chk("m_d9", mem_m[9], 32'h1);
    chk("m_d12", mem_m[12], 32'h8000_0000);
    chk("m_par14", {26'd0, par_m[14]}, 32'h27);
    chk("m_cnt", {16'd0, cnt}, 32'd3);
    chk("m_unc", {31'd0, unc}, 32'd1);
    chk("m_eaddr", eaddr, 32'h38);
    chk("m_irq", 32'(irq_cnt - i0), 32'd4);
    wait_pass("m_pass2");
    en = 1'b0;
    chk("m2_cnt", {16'd0, cnt}, 32'd3);
    chk("m2_wr_n", 32'(wr_cnt - w0), 32'd3);

    // CPU holds the port for 10 cycles while READ is pending
    do_reset();
    v0 = busy_viol;
    bus.CPU_BUSY = 1'b1;
    en = 1'b1;
    repeat (10) @(negedge clk);
    chk("busy_req", {31'd0, bus.SCRUB_REQ}, 32'd0);
    chk("busy_viol", 32'(busy_viol - v0), 32'd0);
    bus.CPU_BUSY = 1'b0;
    #1;
    chk("free_req", {30'd0, bus.SCRUB_REQ, bus.SCRUB_WE}, 32'd2);
    chk("free_addr", bus.SCRUB_ADDR, 32'h0);
    @(negedge clk);
    en = 1'b0;

    // CPU write to the word being corrected cancels the write-back
    do_reset();
    poke(7, 32'h1, 6'h00);
    w0 = wr_cnt;
    en = 1'b1;
    wait_rd("snp_rd7", 32'h1C);
    @(negedge clk);
    @(negedge clk);
    bus.CPU_BUSY = 1'b1;
    @(negedge clk);
    chk("snp_irq", {31'd0, irq}, 32'd1);
    chk("snp_req", {31'd0, bus.SCRUB_REQ}, 32'd0);
    cpu_wdata = 32'h0;
    bus.CPU_ADDR = 32'h1C;
    bus.CPU_WE = 1'b1;
    @(negedge clk);
    bus.CPU_WE = 1'b0;
    bus.CPU_BUSY = 1'b0;
    wait_rd("snp_rd8", 32'h20);
    en = 1'b0;
    chk("snp_wr_n", 32'(wr_cnt - w0), 32'd0);
    chk("snp_cnt", {16'd0, cnt}, 32'd1);

    // saturation, clear, then reset while a write is live
    do_reset();
    poke(3, 32'h1, 6'h00);
    force dut.corr_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.corr_cnt;
    chk("sat_pre", {16'd0, cnt}, 32'hFFFF);
    w0 = wr_cnt;
    en = 1'b1;
    wait_rd("sat_rd3", 32'h0C);
    @(negedge clk);
    @(negedge clk);
    bus.CPU_BUSY = 1'b1;
    @(negedge clk);
    chk("sat_cnt", {16'd0, cnt}, 32'hFFFF);
    chk("sat_eaddr", eaddr, 32'h0C);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_cnt", {16'd0, cnt}, 32'h0);
    chk("clr_eaddr", eaddr, 32'h0);
    chk("clr_unc", {31'd0, unc}, 32'd0);
    bus.CPU_BUSY = 1'b0;
    #1;
    chk("wr_live", {30'd0, bus.SCRUB_REQ, bus.SCRUB_WE}, 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_req", {30'd0, bus.SCRUB_REQ, bus.SCRUB_WE}, 32'd0);
    chk("arst_dout", bus.SCRUB_DOUT, 32'h0);
    chk("arst_addr", bus.SCRUB_ADDR, 32'h0);
    @(negedge clk);
    chk("arst_nowr", 32'(wr_cnt - w0), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/otter_ecc_scrubber.md
# otter_ecc_scrubber

Background memory scrubber and single-error corrector for the OTTER data memory and its 6-bit Hamming parity memory. It walks every word address and reads data and stored parity through the data port, stealing only cycles the CPU leaves idle. It recomputes the check bits and decodes the syndrome, then writes back corrected words through the normal data-write path, which also regenerates parity. It keeps error statistics and raises an interrupt.

## Interface
- `ADDR_WIDTH`, 14: word-address bits; memory holds 2**ADDR_WIDTH words.
- `SCRUB_INTERVAL`, 256: idle cycles between consecutive word checks (0 = back-to-back).
- `READ_LAT`, 1: cycles from SCRUB_REQ (read) to MEM_DIN/PAR_DIN valid.
- `MEM_CLK`  in  1  clock, all logic rising-edge.
- `MEM_RST_N`  in  1  asynchronous, active-low reset.
- `SCRUB_EN`  in  1  enable continuous scrubbing.
- `ERR_CLR`  in  1  synchronous clear of counters and sticky flags.
- `CPU_BUSY`  in  1  CPU owns the data port this cycle; scrubber must not request.
- `CPU_WE`  in  1  CPU write strobe (snoop).
- `CPU_ADDR`  in  32  CPU byte address (snoop).
- `MEM_DIN`  in  32  read data from data memory.
- `PAR_DIN`  in  6  stored check bits from parity memory.
- `SCRUB_REQ`  out  1  scrubber drives the data port this cycle.
- `SCRUB_WE`  out  1  request is a full-word write (else read).
- `SCRUB_ADDR`  out  32  byte address {idx, 2'b00}.
- `SCRUB_DOUT`  out  32  corrected write data.
- `ERR_CORR_CNT`  out  16  corrected-error count, saturating at 16'hFFFF.
- `ERR_UNCORR`  out  1  sticky uncorrectable flag.
- `ERR_ADDR`  out  32  byte address of the most recent error of either kind.
- `ERR_IRQ`  out  1  one-cycle pulse per detected error.
- `PASS_DONE`  out  1  one-cycle pulse when idx wraps to 0.

## Operation
- Reset values: all outputs 0, idx 0, state IDLE, interval counter 0.
- Check-bit encoding is Hamming(38,32).
  - Data bit d0..d31 occupies codeword positions 3,5,6,7,9..15,17..31,33..38 in order; check bit k (k=0..5) sits at position 2**k.
  - Check bit k is the XOR of the data bits whose position has bit k set.
- Syndrome S = PAR_DIN ^ recomputed(MEM_DIN).
  - S==0: clean.
  - S a power of two: check-bit error. Write back MEM_DIN unchanged, which regenerates parity. Counts as corrected.
  - S in 3..38 and not a power of two: flip the data bit at position S, then write back. Counts as corrected.
  - S in 39..63: uncorrectable. No write; set ERR_UNCORR.
  - No double-error detection: a double error decodes as whatever S indicates.
- FSM:
  - IDLE: go to WAIT when SCRUB_EN=1.
  - WAIT: count SCRUB_INTERVAL cycles, then go to READ.
  - READ: hold while CPU_BUSY=1. When CPU_BUSY=0, assert SCRUB_REQ with SCRUB_WE=0 for one cycle, then go to LAT.
  - LAT: wait READ_LAT cycles, then go to CHECK.
  - CHECK: register MEM_DIN, PAR_DIN and S. Go to WRITE if correctable and S!=0; otherwise go to NEXT.
  - WRITE: hold while CPU_BUSY=1. When CPU_BUSY=0, assert SCRUB_REQ and SCRUB_WE for one cycle with the corrected word, then go to NEXT.
  - NEXT: idx+1 modulo 2**ADDR_WIDTH; pulse PASS_DONE on the wrap to 0. Go to WAIT if SCRUB_EN=1, else IDLE.
- Snoop: in LAT, CHECK or WRITE, a CPU write (CPU_WE=1) with CPU_ADDR[ADDR_WIDTH+1:2]==idx cancels the pending write-back. No count or flag for that word; go to NEXT.
- SCRUB_EN dropping mid-word: the current word completes through NEXT, then the FSM enters IDLE.
- Error reporting: ERR_ADDR, ERR_IRQ and counters update in CHECK, even when a later snoop cancels the write.
- ERR_CLR: zeroes ERR_CORR_CNT, ERR_UNCORR and ERR_ADDR. If it coincides with an error event, the event wins (count becomes 1 or the flag is set).

## Timing
- SCRUB_REQ is never high in a cycle with CPU_BUSY=1. The scrubber does no speculative issue.
- Minimum per-word latency with CPU idle and S==0: SCRUB_INTERVAL + 1 (READ) + READ_LAT + 1 (CHECK) + 1 (NEXT) cycles. A correctable error adds 1 cycle (WRITE).
- ERR_IRQ pulses in the cycle after CHECK, alongside the counter/flag update.
- Reset asserted mid-operation aborts any pending write; SCRUB_REQ drops immediately (asynchronous).

## Test plan
- Clean memory: all words 0, parity 0, SCRUB_INTERVAL=0, SCRUB_EN=1. Required: one full pass, PASS_DONE pulses once, no SCRUB_WE, ERR_CORR_CNT=0.
- Data error: idx 5 holds 32'h00000001 with parity 6'b000000 (S=3). Required: write of 32'h00000000 to address 0x14, ERR_CORR_CNT=1, ERR_ADDR=0x14, one ERR_IRQ.
- Check-bit error: data 0 with parity 6'b000100 (S=4). Required: write-back of 0, counter +1. Uncorrectable case: data 0 with parity 6'b111111 (S=63). Required: no write, ERR_UNCORR=1.
- CPU contention: CPU_BUSY held high for 10 cycles while the FSM is in READ. Required: SCRUB_REQ stays 0 throughout and issues on the first free cycle.
- Snoop hazard: correctable error at idx 7; CPU writes 0x1C while the FSM is in WRITE with CPU_BUSY=1. Required: no scrub write, idx advances to 8.
- Saturation and clear: preset the count to 16'hFFFF and inject an error. Required: the count stays 16'hFFFF. Then assert ERR_CLR. Required: all stats 0. Also assert MEM_RST_N=0 mid-WRITE. Required: outputs 0 at once.
